// File: rtl/vga_pixel_out_pkg.sv
// Purpose: shared VGA timing constants and types for the tile generator and pixel output stage.
// Latency: n/a (definitions only).
// Backpressure: n/a; the whole pipeline is free-running from the timing counters.
// Ports: none.
package vga_pixel_out_pkg;

  // Horizontal timing in 50 MHz clocks (two clocks per 25 MHz pixel).
  localparam logic [10:0] HTOTAL      = 11'd1600;
  localparam logic [10:0] HSYNC_CLKS  = 11'd192;
  localparam logic [10:0] HVIS_START  = 11'd224;
  localparam logic [10:0] HVIS_CLKS   = 11'd1280;

  // Vertical timing in lines.
  localparam logic [10:0] VTOTAL      = 11'd521;
  localparam logic [10:0] VSYNC_LINES = 11'd2;
  localparam logic [10:0] VVIS_START  = 11'd12;
  localparam logic [10:0] VVIS_LINES  = 11'd480;

  localparam int PIX_BITS  = 3;
  localparam int WORD_PIX  = 16;
  localparam int WORD_BITS = PIX_BITS * WORD_PIX;

  // Index 0 is the MSB; pixel 0 of a word sits in bits [0:2].
  typedef logic [0:10]          hcnt_t;
  typedef logic [0:9]           vcnt_t;
  typedef logic [0:WORD_BITS-1] word_t;
  typedef logic [0:PIX_BITS-1]  pix_t;

  // Half-open window test [start, start+len), all in 11-bit unsigned.
  function automatic logic in_window(input logic [10:0] val,
                                     input logic [10:0] start,
                                     input logic [10:0] len);
    return (val >= start) && (val < start + len);
  endfunction

endpackage

// File: rtl/vga_pixel_out_if.sv
// Purpose: bundle of timing/pixel inputs and VGA pin outputs of the pixel output stage.
// Latency: n/a (wires only).
// Backpressure: none; master drives counters and pixel words every clock.
// Ports: hcnt, vcnt, pixels (master -> slave); vga_red/green/blue, vga_hsync, vga_vsync, frame_tick (slave -> master).
interface vga_pixel_out_if
  import vga_pixel_out_pkg::*;
();
  hcnt_t hcnt;
  vcnt_t vcnt;
  word_t pixels;
  logic  vga_red;
  logic  vga_green;
  logic  vga_blue;
  logic  vga_hsync;
  logic  vga_vsync;
  logic  frame_tick;

  modport master (
    output hcnt, vcnt, pixels,
    input  vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_tick
  );

  modport slave (
    input  hcnt, vcnt, pixels,
    output vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_tick
  );
endinterface

// File: rtl/vga_pixel_out_shift16x3.sv
// Purpose: 48-bit load/shift register presenting one 3-bit pixel, each pixel held for two clocks.
// Latency: loaded word appears on pix_o the clock after load_i.
// Backpressure: none; load_i always wins over the shift.
// Ports: clk_i, rst_i (async, active high), load_i, din_i[0:47], pix_o[0:2].
module vga_shift16x3
  import vga_pixel_out_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  word_t din_i,
  output pix_t  pix_o
);

  word_t shreg_q, shreg_d;
  logic  phase_q, phase_d;

  // phase=1 marks the second clock of the current pixel, so the shift happens then.
  always_comb begin
    shreg_d = shreg_q;
    phase_d = phase_q;
    if (load_i) begin
      shreg_d = din_i;
      phase_d = 1'b1;
    end else begin
      if (phase_q) begin
        shreg_d = shreg_q << PIX_BITS;
      end
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      phase_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      phase_q <= phase_d;
    end
  end

  assign pix_o = shreg_q[0:PIX_BITS-1];

endmodule

// File: rtl/vga_pixel_out.sv
// Purpose: serialize 16-pixel words to VGA RGB with blanking, registered syncs and a frame tick.
// Latency: 1 clock from hcnt/vcnt/pixels to every output (RGB and syncs share one register stage).
// Backpressure: none; a word is captured only on 32-clock visible boundaries, otherwise pixels is ignored.
// Ports: clk_i, rst_i (async, active high), bus (slave modport of vga_pixel_out_if).
module vga_pixel_out
  import vga_pixel_out_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  vga_pixel_out_if.slave  bus
);

  logic h_vis, v_vis, vis, load;
  pix_t shift_pix, pix_sel;

  pix_t rgb_q, rgb_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic tick_q, tick_d;

  assign h_vis = in_window(bus.hcnt, HVIS_START, HVIS_CLKS);
  assign v_vis = in_window({1'b0, bus.vcnt}, VVIS_START, VVIS_LINES);
  assign vis   = h_vis & v_vis;

  // Word boundary every 32 clocks into the visible span; the h_vis guard
  // masks the wrapped result of the subtraction left of HVIS_START.
  assign load = h_vis && (((bus.hcnt - HVIS_START) & 11'd31) == 11'd0);

  vga_shift16x3 u_shift (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .din_i  (bus.pixels),
    .pix_o  (shift_pix)
  );

  // On the load clock the register still holds the old word, so bypass it.
  assign pix_sel = load ? bus.pixels[0:PIX_BITS-1] : shift_pix;

  always_comb begin
    rgb_d   = vis ? pix_sel : '0;
    hsync_d = !(bus.hcnt < HSYNC_CLKS);
    vsync_d = !({1'b0, bus.vcnt} < VSYNC_LINES);
    tick_d  = (bus.hcnt == HVIS_START) &&
              ({1'b0, bus.vcnt} == VVIS_START + VVIS_LINES);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.vga_red    = rgb_q[0];
  assign bus.vga_green  = rgb_q[1];
  assign bus.vga_blue   = rgb_q[2];
  assign bus.vga_hsync  = hsync_q;
  assign bus.vga_vsync  = vsync_q;
  assign bus.frame_tick = tick_q;

endmodule
